// File: rtl/mem_arbiter_pkg.sv
// Shared bus types and sizing constants for the memory-port arbiter.
// Imported by the interface, the tag table and the arbiter top.
package mem_arbiter_pkg;

    localparam int XLEN             = 32;
    localparam int MEM_TAG_W        = 4;
    localparam int NUM_MEM_TAGS     = 15;
    localparam int ARB_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } ARB_OWNER;

    // The D-side may issue stores; the I-side only loads.
    function automatic logic is_mem_req(input BUS_COMMAND cmd, input logic allow_store);
        return (cmd == BUS_LOAD) || (allow_store && (cmd == BUS_STORE));
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals around the arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    BUS_COMMAND              icache2arb_command;
    logic [XLEN-1:0]         icache2arb_addr;
    logic [MEM_TAG_W-1:0]    arb2icache_response;
    logic [63:0]             arb2icache_data;
    logic [MEM_TAG_W-1:0]    arb2icache_tag;

    BUS_COMMAND              dcache2arb_command;
    logic [XLEN-1:0]         dcache2arb_addr;
    logic [63:0]             dcache2arb_data;
    MEM_SIZE                 dcache2arb_size;
    logic [MEM_TAG_W-1:0]    arb2dcache_response;
    logic [63:0]             arb2dcache_data;
    logic [MEM_TAG_W-1:0]    arb2dcache_tag;

    BUS_COMMAND              proc2mem_command;
    logic [XLEN-1:0]         proc2mem_addr;
    logic [63:0]             proc2mem_data;
    MEM_SIZE                 proc2mem_size;
    logic [MEM_TAG_W-1:0]    mem2proc_response;
    logic [63:0]             mem2proc_data;
    logic [MEM_TAG_W-1:0]    mem2proc_tag;

    modport slave (
        input  icache2arb_command, icache2arb_addr,
        input  dcache2arb_command, dcache2arb_addr, dcache2arb_data, dcache2arb_size,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output arb2icache_response, arb2icache_data, arb2icache_tag,
        output arb2dcache_response, arb2dcache_data, arb2dcache_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

    modport master (
        output icache2arb_command, icache2arb_addr,
        output dcache2arb_command, dcache2arb_addr, dcache2arb_data, dcache2arb_size,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  arb2icache_response, arb2icache_data, arb2icache_tag,
        input  arb2dcache_response, arb2dcache_data, arb2dcache_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Outstanding-tag ownership table: one allocate port, one lookup+free port.
// Allocation wins over a same-cycle free of the same tag; lookup reads the old contents.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int TAG_W    = MEM_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_alloc_en,
    input  logic [TAG_W-1:0] i_alloc_tag,
    input  ARB_OWNER         i_alloc_owner,
    input  logic             i_free_en,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_lookup_valid,
    output ARB_OWNER         o_lookup_owner
);

    // Entry 0 is never written: tag 0 means "no tag".
    logic [NUM_TAGS:0] r_valid;
    logic [NUM_TAGS:0] r_owner_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= '0;
            r_owner_d <= '0;
        end else begin
            if (i_free_en) begin
                r_valid[i_lookup_tag] <= 1'b0;
            end
            if (i_alloc_en) begin
                r_valid[i_alloc_tag]   <= 1'b1;
                r_owner_d[i_alloc_tag] <= (i_alloc_owner == ARB_DCACHE);
            end
        end
    end

    assign o_lookup_valid = (i_lookup_tag != '0) && r_valid[i_lookup_tag];
    assign o_lookup_owner = r_owner_d[i_lookup_tag] ? ARB_DCACHE : ARB_ICACHE;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between I-cache and D-cache and routes returning tags to their owner.
// MEM_ARB_FAIR_EN selects round-robin grant; default is D-side priority with I-side starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = NUM_MEM_TAGS,
    parameter int TAG_W        = MEM_TAG_W,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic         arb_error
);

    logic             w_i_req;
    logic             w_d_req;
    logic             w_win_i;
    logic             w_grant;
    logic             w_accept;
    ARB_OWNER         w_winner;
    logic [TAG_W-1:0] w_ret_tag;
    logic             w_lk_valid;
    ARB_OWNER         w_lk_owner;
    logic             w_ret_hit;
    logic             w_ret_miss;
    logic             r_arb_error;

    // Requests are masked while reset is low so every output collapses to idle.
    assign w_i_req  = reset && is_mem_req(bus.icache2arb_command, 1'b0);
    assign w_d_req  = reset && is_mem_req(bus.dcache2arb_command, 1'b1);
    assign w_grant  = w_i_req || w_d_req;
    assign w_accept = w_grant && (bus.mem2proc_response != '0);
    assign w_winner = w_win_i ? ARB_ICACHE : ARB_DCACHE;

`ifdef MEM_ARB_FAIR_EN
    ARB_OWNER r_last_grant;

    always_comb begin
        w_win_i = w_i_req;
        if (w_i_req && w_d_req) begin
            w_win_i = (r_last_grant == ARB_DCACHE);
        end
    end

    // Rejected commands leave history alone so the same side retries first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= ARB_DCACHE;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
        end
    end
`else
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_starved;

    assign w_starved = (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
    assign w_win_i   = w_i_req && (!w_d_req || w_starved);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_accept && w_win_i) begin
            r_starve_cnt <= '0;
        end else if (w_i_req && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        bus.proc2mem_command    = BUS_NONE;
        bus.proc2mem_addr       = '0;
        bus.proc2mem_data       = '0;
        bus.proc2mem_size       = BYTE;
        bus.arb2icache_response = '0;
        bus.arb2dcache_response = '0;
        if (w_win_i) begin
            bus.proc2mem_command    = BUS_LOAD;
            bus.proc2mem_addr       = bus.icache2arb_addr;
            bus.proc2mem_size       = DOUBLE;
            bus.arb2icache_response = bus.mem2proc_response;
        end else if (w_d_req) begin
            bus.proc2mem_command    = bus.dcache2arb_command;
            bus.proc2mem_addr       = bus.dcache2arb_addr;
            bus.proc2mem_data       = bus.dcache2arb_data;
            bus.proc2mem_size       = bus.dcache2arb_size;
            bus.arb2dcache_response = bus.mem2proc_response;
        end
    end

    assign w_ret_tag  = bus.mem2proc_tag;
    assign w_ret_hit  = reset && (w_ret_tag != '0) && w_lk_valid;
    assign w_ret_miss = reset && (w_ret_tag != '0) && !w_lk_valid;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_table (
        .clock          (clock),
        .reset          (reset),
        .i_alloc_en     (w_accept),
        .i_alloc_tag    (bus.mem2proc_response),
        .i_alloc_owner  (w_winner),
        .i_free_en      (w_ret_hit),
        .i_lookup_tag   (w_ret_tag),
        .o_lookup_valid (w_lk_valid),
        .o_lookup_owner (w_lk_owner)
    );

    always_comb begin
        bus.arb2icache_tag  = '0;
        bus.arb2icache_data = '0;
        bus.arb2dcache_tag  = '0;
        bus.arb2dcache_data = '0;
        if (w_ret_hit) begin
            if (w_lk_owner == ARB_ICACHE) begin
                bus.arb2icache_tag  = w_ret_tag;
                bus.arb2icache_data = bus.mem2proc_data;
            end else begin
                bus.arb2dcache_tag  = w_ret_tag;
                bus.arb2dcache_data = bus.mem2proc_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_arb_error <= 1'b0;
        end else if (w_ret_miss) begin
            r_arb_error <= 1'b1;
        end
    end

    assign arb_error = r_arb_error;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expectations, a negedge monitor pops them.
// Grant-order expectations follow MEM_ARB_FAIR_EN the same way the design does.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        BUS_COMMAND  cmd;
        logic [31:0] addr;
        logic [63:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] data;
    } ret_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic arb_error;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] q_i_resp[$];
    logic [3:0] q_d_resp[$];
    ret_exp_t   q_i_ret[$];
    ret_exp_t   q_d_ret[$];
    mem_exp_t   q_mem[$];

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .arb_error (arb_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // Monitor: every visible DUT output must match the oldest queued expectation.
    always @(negedge clock) begin
        ret_exp_t r;
        mem_exp_t m;
        if (bus.arb2icache_response != '0) begin
            if (q_i_resp.size() == 0) unexpected("icache_resp", 64'(bus.arb2icache_response));
            else check("icache_resp", 64'(bus.arb2icache_response), 64'(q_i_resp.pop_front()));
        end
        if (bus.arb2dcache_response != '0) begin
            if (q_d_resp.size() == 0) unexpected("dcache_resp", 64'(bus.arb2dcache_response));
            else check("dcache_resp", 64'(bus.arb2dcache_response), 64'(q_d_resp.pop_front()));
        end
        if (bus.arb2icache_tag != '0) begin
            if (q_i_ret.size() == 0) unexpected("icache_ret_tag", 64'(bus.arb2icache_tag));
            else begin
                r = q_i_ret.pop_front();
                check("icache_ret_tag", 64'(bus.arb2icache_tag), 64'(r.tag));
                check("icache_ret_data", bus.arb2icache_data, r.data);
            end
        end else if (bus.arb2icache_data != '0) begin
            unexpected("icache_data_no_tag", bus.arb2icache_data);
        end
        if (bus.arb2dcache_tag != '0) begin
            if (q_d_ret.size() == 0) unexpected("dcache_ret_tag", 64'(bus.arb2dcache_tag));
            else begin
                r = q_d_ret.pop_front();
                check("dcache_ret_tag", 64'(bus.arb2dcache_tag), 64'(r.tag));
                check("dcache_ret_data", bus.arb2dcache_data, r.data);
            end
        end else if (bus.arb2dcache_data != '0) begin
            unexpected("dcache_data_no_tag", bus.arb2dcache_data);
        end
        if (bus.proc2mem_command != BUS_NONE) begin
            if (q_mem.size() == 0) unexpected("mem_cmd", 64'(bus.proc2mem_command));
            else begin
                m = q_mem.pop_front();
                check("mem_cmd", 64'(bus.proc2mem_command), 64'(m.cmd));
                check("mem_addr", 64'(bus.proc2mem_addr), 64'(m.addr));
                check("mem_data", bus.proc2mem_data, m.data);
            end
        end else if (bus.proc2mem_addr != '0 || bus.proc2mem_data != '0) begin
            unexpected("mem_idle_bus", 64'(bus.proc2mem_addr) | bus.proc2mem_data);
        end
    end

    task automatic drive_idle();
        bus.icache2arb_command = BUS_NONE;
        bus.icache2arb_addr    = '0;
        bus.dcache2arb_command = BUS_NONE;
        bus.dcache2arb_addr    = '0;
        bus.dcache2arb_data    = '0;
        bus.dcache2arb_size    = DOUBLE;
        bus.mem2proc_response  = '0;
        bus.mem2proc_data      = '0;
        bus.mem2proc_tag       = '0;
    endtask

    // One cycle of stimulus plus its hand-computed expected outputs (e_ret: 0 none, 1 I-side, 2 D-side).
    task automatic vec(input BUS_COMMAND icmd, input logic [31:0] iaddr,
                       input BUS_COMMAND dcmd, input logic [31:0] daddr, input logic [63:0] ddata,
                       input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata,
                       input logic [3:0] e_ir, input logic [3:0] e_dr, input int e_ret,
                       input BUS_COMMAND e_cmd, input logic [31:0] e_addr, input logic [63:0] e_data);
        mem_exp_t m;
        ret_exp_t r;
        @(posedge clock);
        #1;
        bus.icache2arb_command = icmd;
        bus.icache2arb_addr    = iaddr;
        bus.dcache2arb_command = dcmd;
        bus.dcache2arb_addr    = daddr;
        bus.dcache2arb_data    = ddata;
        bus.dcache2arb_size    = DOUBLE;
        bus.mem2proc_response  = mresp;
        bus.mem2proc_tag       = mtag;
        bus.mem2proc_data      = mdata;
        if (e_ir != '0) q_i_resp.push_back(e_ir);
        if (e_dr != '0) q_d_resp.push_back(e_dr);
        r.tag  = mtag;
        r.data = mdata;
        if (e_ret == 1) q_i_ret.push_back(r);
        if (e_ret == 2) q_d_ret.push_back(r);
        if (e_cmd != BUS_NONE) begin
            m.cmd  = e_cmd;
            m.addr = e_addr;
            m.data = e_data;
            q_mem.push_back(m);
        end
    endtask

    task automatic idle();
        vec(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0, 0, 0, 0, BUS_NONE, 0, 0);
    endtask

    task automatic ret(input logic [3:0] tag, input logic [63:0] data, input int side);
        vec(BUS_NONE, 0, BUS_NONE, 0, 0, 0, tag, data, 0, 0, side, BUS_NONE, 0, 0);
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_mem_cmd"},  64'(bus.proc2mem_command), 64'(BUS_NONE));
        check({tagname, "_mem_addr"}, 64'(bus.proc2mem_addr), 64'h0);
        check({tagname, "_mem_data"}, bus.proc2mem_data, 64'h0);
        check({tagname, "_i_resp"},   64'(bus.arb2icache_response), 64'h0);
        check({tagname, "_d_resp"},   64'(bus.arb2dcache_response), 64'h0);
        check({tagname, "_i_tag"},    64'(bus.arb2icache_tag), 64'h0);
        check({tagname, "_d_tag"},    64'(bus.arb2dcache_tag), 64'h0);
        check({tagname, "_i_data"},   bus.arb2icache_data, 64'h0);
        check({tagname, "_d_data"},   bus.arb2dcache_data, 64'h0);
        check({tagname, "_arb_error"}, 64'(arb_error), 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_idle();
        #1;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] t;
        logic       win_i;
        drive_idle();

        // 1: single D-side load, later its return
        do_reset();
        vec(BUS_NONE, 0, BUS_LOAD, 32'h100, 0, 4'd3, 0, 0, 0, 4'd3, 0, BUS_LOAD, 32'h100, 0);
        idle();
        ret(4'd3, 64'hDEAD, 2);
        idle();
        check("t1_arb_error", 64'(arb_error), 64'h0);

        // 2: both sides request every cycle, memory always accepts
        do_reset();
        for (int k = 0; k < 18; k++) begin
            t = 4'((k % 15) + 1);
`ifdef MEM_ARB_FAIR_EN
            win_i = (k % 2 == 0);
`else
            win_i = (k % 9 == 8);
`endif
            if (win_i)
                vec(BUS_LOAD, 32'h2000, BUS_STORE, 32'h3000, 64'h55AA, t, 0, 0,
                    t, 0, 0, BUS_LOAD, 32'h2000, 0);
            else
                vec(BUS_LOAD, 32'h2000, BUS_STORE, 32'h3000, 64'h55AA, t, 0, 0,
                    0, t, 0, BUS_STORE, 32'h3000, 64'h55AA);
        end
        idle();
        ret(4'd1, 64'h1111, 2);   // re-allocated to D-side at k=15
        ret(4'd9, 64'h9999, 1);   // allocated to I-side at k=8
        idle();
        check("t2_arb_error", 64'(arb_error), 64'h0);

        // 3: three rejections, then the same side is accepted
        do_reset();
`ifdef MEM_ARB_FAIR_EN
        win_i = 1'b1;
`else
        win_i = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            t = (k == 3) ? 4'd6 : 4'd0;
            if (win_i)
                vec(BUS_LOAD, 32'h2000, BUS_LOAD, 32'h3000, 0, t, 0, 0,
                    t, 0, 0, BUS_LOAD, 32'h2000, 0);
            else
                vec(BUS_LOAD, 32'h2000, BUS_LOAD, 32'h3000, 0, t, 0, 0,
                    0, t, 0, BUS_LOAD, 32'h3000, 0);
        end
        idle();
        ret(4'd6, 64'h6666, win_i ? 1 : 2);
        idle();
        check("t3_arb_error", 64'(arb_error), 64'h0);

        // 4: tag 5 returns to I-side while being re-issued to D-side
        do_reset();
        vec(BUS_LOAD, 32'h500, BUS_NONE, 0, 0, 4'd5, 0, 0, 4'd5, 0, 0, BUS_LOAD, 32'h500, 0);
        vec(BUS_NONE, 0, BUS_LOAD, 32'h600, 0, 4'd5, 4'd5, 64'hBEEF,
            0, 4'd5, 1, BUS_LOAD, 32'h600, 0);
        ret(4'd5, 64'hCAFE, 2);
        idle();
        check("t4_arb_error", 64'(arb_error), 64'h0);

        // 5: unallocated return is dropped and sets a sticky error
        ret(4'd7, 64'h7777, 0);
        idle();
        check("t5_arb_error_set", 64'(arb_error), 64'h1);
        idle();
        idle();
        idle();
        check("t5_arb_error_sticky", 64'(arb_error), 64'h1);

        // 6: reset with tags 2 and 4 outstanding
        do_reset();
        vec(BUS_NONE, 0, BUS_LOAD, 32'h700, 0, 4'd2, 0, 0, 0, 4'd2, 0, BUS_LOAD, 32'h700, 0);
        vec(BUS_LOAD, 32'h800, BUS_NONE, 0, 0, 4'd4, 0, 0, 4'd4, 0, 0, BUS_LOAD, 32'h800, 0);
        @(posedge clock);
        #1;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h880;
        bus.dcache2arb_command = BUS_STORE;
        bus.dcache2arb_addr    = 32'h900;
        bus.dcache2arb_data    = 64'h1234;
        bus.mem2proc_response  = 4'd3;
        bus.mem2proc_tag       = 4'd2;
        bus.mem2proc_data      = 64'h2222;
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("midflight_reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        drive_idle();
        reset = 1'b1;
        ret(4'd2, 64'h2222, 0);
        idle();
        check("t6_arb_error_tag2", 64'(arb_error), 64'h1);
        ret(4'd4, 64'h4444, 0);
        idle();
        idle();

        check("left_i_resp", 64'(q_i_resp.size()), 64'h0);
        check("left_d_resp", 64'(q_d_resp.size()), 64'h0);
        check("left_i_ret",  64'(q_i_ret.size()),  64'h0);
        check("left_d_ret",  64'(q_d_ret.size()),  64'h0);
        check("left_mem",    64'(q_mem.size()),    64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
